// File: rtl/uci_move_printer.sv
// rtl/uci_move_printer.sv - prints buffered chess moves as UCI text lines, plus an optional move-count line
// Moves queue in a small FIFO; each becomes "<from><to>[promo]" + SEP, and done_in appends the decimal count.
module uci_move_printer #(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] SEP      = 8'h0A,
  parameter bit         COUNT_EN = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [5:0] from_in,
  input  logic [5:0] to_in,
  input  logic [2:0] promo_in,
  input  logic       move_in_valid,
  output logic       move_in_ready,
  input  logic       done_in,
  output logic [7:0] char_out,
  output logic       char_out_valid,
  input  logic       char_out_ready,
  output logic       busy_out
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EMIT, S_CONV, S_CNT} state_t;

  // Entry layout: {from[5:0], to[5:0], promo[2:0]}
  logic [14:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  state_t      r_state;
  logic [14:0] r_hold;
  logic [2:0]  r_idx;
  logic [7:0]  r_char;
  logic        r_valid;
  logic        r_done;
  logic [7:0]  r_moves;
  logic        r_busy;
  logic [7:0]  r_rem;
  logic [1:0]  r_h;
  logic [3:0]  r_t;
  logic [3:0]  r_o;
  logic [1:0]  r_didx;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_xfer;
  logic [14:0] w_head;
  logic [7:0]  w_cnt_next;

  function automatic logic [7:0] move_char(input logic [14:0] mv, input logic [2:0] idx);
    logic [7:0] c;
    c = SEP;
    case (idx)
      3'd0: c = 8'h61 + {5'd0, mv[11:9]};
      3'd1: c = 8'h31 + {5'd0, mv[14:12]};
      3'd2: c = 8'h61 + {5'd0, mv[5:3]};
      3'd3: c = 8'h31 + {5'd0, mv[8:6]};
      3'd4: begin
        case (mv[2:0])
          3'd1:    c = 8'h6E;
          3'd2:    c = 8'h62;
          3'd3:    c = 8'h72;
          3'd4:    c = 8'h71;
          default: c = SEP;
        endcase
      end
      default: c = SEP;
    endcase
    return c;
  endfunction

  // Index of the SEP character: 5 when a promotion letter is printed, else 4
  function automatic logic [2:0] last_idx(input logic [2:0] pr);
    return (pr >= 3'd1 && pr <= 3'd4) ? 3'd5 : 3'd4;
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] d);
    return 8'h30 + {4'd0, d};
  endfunction

  assign w_full        = (r_count == FULL_CNT);
  assign w_empty       = (r_count == '0);
  assign move_in_ready = rst_in & ~w_full & ~r_done;
  assign w_push        = move_in_valid & move_in_ready;
  assign w_xfer        = r_valid & char_out_ready;
  assign w_head        = r_mem[r_rd_ptr];
  // A slot is freed only once its line has fully left, so a stalled line still occupies the FIFO
  assign w_pop         = (r_state == S_EMIT) & w_xfer & (r_idx == last_idx(r_hold[2:0]));

  assign char_out       = r_char;
  assign char_out_valid = r_valid;
  assign busy_out       = r_busy;

  always_comb begin
    w_cnt_next = SEP;
    case (r_didx)
      2'd0:    w_cnt_next = digit(r_t);
      2'd1:    w_cnt_next = digit(r_o);
      default: w_cnt_next = SEP;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= {from_in, to_in, promo_in};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_moves <= '0;
      r_busy  <= 1'b0;
      r_rem   <= '0;
      r_h     <= '0;
      r_t     <= '0;
      r_o     <= '0;
      r_didx  <= '0;
    end else begin
      r_busy <= ~w_empty | (r_state != S_IDLE) | r_done;
      if (w_push && r_moves != 8'hFF) r_moves <= r_moves + 8'd1;
      if (done_in && !r_done) r_done <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_char  <= move_char(w_head, 3'd0);
            r_valid <= 1'b1;
            r_idx   <= 3'd0;
            r_state <= S_LOAD;
          end else if (r_done) begin
            if (COUNT_EN) begin
              r_rem   <= r_moves;
              r_h     <= '0;
              r_t     <= '0;
              r_state <= S_CONV;
            end else begin
              r_done  <= 1'b0;
              r_moves <= '0;
            end
          end
        end
        S_LOAD: begin
          r_hold  <= w_head;
          r_state <= S_EMIT;
          if (w_xfer) begin
            r_idx  <= 3'd1;
            r_char <= move_char(w_head, 3'd1);
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            if (r_idx == last_idx(r_hold[2:0])) begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_char <= move_char(r_hold, r_idx + 3'd1);
            end
          end
        end
        S_CONV: begin
          if (r_rem >= 8'd100) begin
            r_rem <= r_rem - 8'd100;
            r_h   <= r_h + 2'd1;
          end else if (r_rem >= 8'd10) begin
            r_rem <= r_rem - 8'd10;
            r_t   <= r_t + 4'd1;
          end else begin
            // Start at the first non-zero digit; ones always prints
            r_o     <= r_rem[3:0];
            r_valid <= 1'b1;
            r_state <= S_CNT;
            if (r_h != 2'd0) begin
              r_didx <= 2'd0;
              r_char <= digit({2'b00, r_h});
            end else if (r_t != 4'd0) begin
              r_didx <= 2'd1;
              r_char <= digit(r_t);
            end else begin
              r_didx <= 2'd2;
              r_char <= digit(r_rem[3:0]);
            end
          end
        end
        S_CNT: begin
          if (w_xfer) begin
            if (r_didx == 2'd3) begin
              r_valid <= 1'b0;
              r_done  <= 1'b0;
              r_moves <= '0;
              r_state <= S_IDLE;
            end else begin
              r_didx <= r_didx + 2'd1;
              r_char <= w_cnt_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uci_move_printer.sv
// tb/tb_uci_move_printer.sv - randomized self-checking bench for uci_move_printer
// Expected text is built from square arithmetic and decimal formatting, compared to the captured stream.
module tb_uci_move_printer;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [5:0] from_in, to_in;
  logic [2:0] promo_in;
  logic       move_in_valid, move_in_ready, done_in;
  logic [7:0] char_out;
  logic       char_out_valid, char_out_ready, busy_out;

  logic [5:0] b_from, b_to;
  logic [2:0] b_promo;
  logic       b_mvalid, b_mready, b_done;
  logic [7:0] b_char;
  logic       b_cvalid, b_cready, b_busy;

  always #5 clk = ~clk;

  uci_move_printer dut (
    .clk_in(clk), .rst_in(rst_in), .from_in(from_in), .to_in(to_in), .promo_in(promo_in),
    .move_in_valid(move_in_valid), .move_in_ready(move_in_ready), .done_in(done_in),
    .char_out(char_out), .char_out_valid(char_out_valid), .char_out_ready(char_out_ready),
    .busy_out(busy_out)
  );

  uci_move_printer #(.COUNT_EN(1'b0)) dut_nocount (
    .clk_in(clk), .rst_in(rst_in), .from_in(b_from), .to_in(b_to), .promo_in(b_promo),
    .move_in_valid(b_mvalid), .move_in_ready(b_mready), .done_in(b_done),
    .char_out(b_char), .char_out_valid(b_cvalid), .char_out_ready(b_cready),
    .busy_out(b_busy)
  );

  int    n_pass = 0;
  int    n_total = 0;
  int    timeouts = 0;
  int    cyc = 0;
  string cap = "";
  string cap2 = "";
  int    xfer_cyc[$];
  int    last_acc_cyc = 0;
  int    first_valid_cyc = 0;
  logic  prev_valid = 1'b0;
  logic  prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;
  int    stall_errs = 0;
  int    stall_seen = 0;
  int    busy2_cycles = 0;
  bit    rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are observed mid-cycle: valid&ready here means the char leaves at the next edge
  always @(negedge clk) begin
    if (rst_in && char_out_valid && char_out_ready) begin
      cap = $sformatf("%s%c", cap, char_out);
      xfer_cyc.push_back(cyc);
    end
    if (rst_in && move_in_valid && move_in_ready) last_acc_cyc = cyc;
    if (rst_in && char_out_valid && !prev_valid) first_valid_cyc = cyc;
    if (prev_stall && rst_in) begin
      stall_seen++;
      if (!char_out_valid || char_out !== prev_char) stall_errs++;
    end
    prev_stall = rst_in && char_out_valid && !char_out_ready;
    prev_char  = char_out;
    prev_valid = rst_in && char_out_valid;
    if (rst_in && b_cvalid && b_cready) cap2 = $sformatf("%s%c", cap2, b_char);
    if (b_busy) busy2_cycles++;
  end

  function automatic string move_line(int f, int t, int p);
    string s;
    string pl;
    pl = "nbrq";
    s = $sformatf("%c%c%c%c", 8'h61 + f % 8, 8'h31 + f / 8, 8'h61 + t % 8, 8'h31 + t / 8);
    if (p >= 1 && p <= 4) s = $sformatf("%s%c", s, pl[p-1]);
    return {s, "\n"};
  endfunction

  function automatic string count_line(int n);
    return $sformatf("%0d\n", (n > 255) ? 255 : n);
  endfunction

  function automatic string tail(string s, int base);
    if (base >= s.len()) return "";
    return s.substr(base, s.len() - 1);
  endfunction

  function automatic int first_diff(string a, string b);
    int n;
    n = (a.len() < b.len()) ? a.len() : b.len();
    for (int i = 0; i < n; i++) if (a[i] != b[i]) return i;
    return n;
  endfunction

  function automatic logic [7:0] char_at(string s, int i);
    if (i < s.len()) return s[i];
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) char_out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic apply_reset();
    rst_in = 1'b0;
    move_in_valid = 1'b0;
    done_in = 1'b0;
    b_done = 1'b0;
    rand_ready = 1'b0;
    repeat (3) tick();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic send_move(int f, int t, int p);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    from_in = 6'(f);
    to_in = 6'(t);
    promo_in = 3'(p);
    move_in_valid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = move_in_ready;
      tick();
      n++;
    end
    move_in_valid = 1'b0;
    if (!acc) timeouts++;
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < 5000) begin
      tick();
      n++;
      if (!busy_out && !char_out_valid) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) timeouts++;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    move_in_valid = 1'b0;
    done_in = 1'b0;
    char_out_ready = 1'b1;
    repeat (2) tick();
    n_total++; if (char_out !== 8'h00) $display("FAIL reset_char: got %h want 00", char_out); else n_pass++;
    n_total++; if (char_out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", char_out_valid); else n_pass++;
    n_total++; if (move_in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", move_in_ready); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_out); else n_pass++;
    rst_in = 1'b1;
    #1;
    n_total++; if (move_in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", move_in_ready); else n_pass++;
    n_total++; if (char_out_valid !== 1'b0) $display("FAIL valid_after_reset: got %b want 0", char_out_valid); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL busy_after_reset: got %b want 0", busy_out); else n_pass++;
  endtask

  task automatic test_latency_e2e4();
    int base;
    string got, want;
    apply_reset();
    char_out_ready = 1'b1;
    base = cap.len();
    send_move(12, 28, 0);
    wait_idle();
    n_total++;
    if (first_valid_cyc - last_acc_cyc !== 2)
      $display("FAIL latency: got %0d cycles want 2", first_valid_cyc - last_acc_cyc);
    else n_pass++;
    got = tail(cap, base);
    want = move_line(12, 28, 0);
    n_total++;
    if (got != want)
      $display("FAIL e2e4_text: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
  endtask

  task automatic test_promo_count();
    int base;
    string got, want;
    apply_reset();
    char_out_ready = 1'b1;
    base = cap.len();
    send_move(48, 56, 4);
    pulse_done();
    wait_idle();
    got = tail(cap, base);
    want = {move_line(48, 56, 4), count_line(1)};
    n_total++;
    if (got != want)
      $display("FAIL promo_count: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    int base, accepted, f, t, p;
    string got, want;
    apply_reset();
    char_out_ready = 1'b0;
    base = cap.len();
    accepted = 0;
    want = "";
    f = $urandom_range(0, 63); t = $urandom_range(0, 63); p = $urandom_range(0, 7);
    from_in = 6'(f); to_in = 6'(t); promo_in = 3'(p);
    move_in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bit took;
      @(negedge clk);
      took = move_in_ready;
      tick();
      if (took) begin
        accepted++;
        want = {want, move_line(f, t, p)};
        f = $urandom_range(0, 63); t = $urandom_range(0, 63); p = $urandom_range(0, 7);
        from_in = 6'(f); to_in = 6'(t); promo_in = 3'(p);
      end
    end
    n_total++; if (accepted !== 8) $display("FAIL full_accepts: got %0d want 8", accepted); else n_pass++;
    n_total++; if (move_in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", move_in_ready); else n_pass++;
    move_in_valid = 1'b0;
    char_out_ready = 1'b1;
    wait_idle();
    got = tail(cap, base);
    n_total++;
    if (got != want)
      $display("FAIL full_drain: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base, xbase, max_gap, f, t;
    string got, want;
    apply_reset();
    char_out_ready = 1'b0;
    base = cap.len();
    want = "";
    for (int i = 0; i < 4; i++) begin
      f = $urandom_range(0, 63); t = $urandom_range(0, 63);
      send_move(f, t, 0);
      want = {want, move_line(f, t, 0)};
    end
    xbase = xfer_cyc.size();
    char_out_ready = 1'b1;
    wait_idle();
    max_gap = 0;
    for (int i = xbase + 1; i < xfer_cyc.size(); i++)
      if (xfer_cyc[i] - xfer_cyc[i-1] > max_gap) max_gap = xfer_cyc[i] - xfer_cyc[i-1];
    n_total++; if (max_gap > 3) $display("FAIL b2b_gap: got %0d dead cycles want at most 2", max_gap - 1); else n_pass++;
    got = tail(cap, base);
    n_total++;
    if (got != want)
      $display("FAIL b2b_text: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
  endtask

  task automatic test_empty_list();
    int base, base2, busy2_base;
    string got, got2;
    apply_reset();
    char_out_ready = 1'b1;
    b_cready = 1'b1;
    base = cap.len();
    pulse_done();
    wait_idle();
    got = tail(cap, base);
    n_total++;
    if (got != count_line(0)) $display("FAIL empty_count: got len %0d first %h want \"0\\n\"", got.len(), char_at(got, 0));
    else n_pass++;
    base2 = cap2.len();
    busy2_base = busy2_cycles;
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    repeat (10) tick();
    got2 = tail(cap2, base2);
    n_total++; if (got2.len() !== 0) $display("FAIL nocount_output: got %0d chars want 0", got2.len()); else n_pass++;
    n_total++;
    if (busy2_cycles - busy2_base < 1 || b_busy !== 1'b0)
      $display("FAIL nocount_busy: busy cycles %0d final %b want >=1 then 0", busy2_cycles - busy2_base, b_busy);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    int base, se, ss, f, t, p;
    bit used[4096];
    string got, want;
    apply_reset();
    rand_ready = 1'b1;
    base = cap.len();
    se = stall_errs;
    ss = stall_seen;
    want = "";
    for (int i = 0; i < 4096; i++) used[i] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      do begin
        f = $urandom_range(0, 63); t = $urandom_range(0, 63);
      end while (f == t || used[f * 64 + t]);
      used[f * 64 + t] = 1'b1;
      p = $urandom_range(0, 7);
      send_move(f, t, p);
      want = {want, move_line(f, t, p)};
    end
    pulse_done();
    want = {want, count_line(20)};
    wait_idle();
    rand_ready = 1'b0;
    char_out_ready = 1'b1;
    got = tail(cap, base);
    n_total++;
    if (got != want)
      $display("FAIL random_text: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
    n_total++;
    if (stall_errs - se !== 0 || stall_seen - ss < 1)
      $display("FAIL stall_stable: got %0d unstable of %0d stalls want 0 unstable", stall_errs - se, stall_seen - ss);
    else n_pass++;
  endtask

  task automatic test_saturate();
    int base, f, t, p;
    string got, want;
    apply_reset();
    char_out_ready = 1'b1;
    base = cap.len();
    want = "";
    for (int i = 0; i < 260; i++) begin
      f = $urandom_range(0, 63); t = $urandom_range(0, 63); p = $urandom_range(0, 7);
      send_move(f, t, p);
      want = {want, move_line(f, t, p)};
    end
    pulse_done();
    want = {want, count_line(260)};
    wait_idle();
    got = tail(cap, base);
    n_total++;
    if (got != want)
      $display("FAIL saturate_text: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
  endtask

  task automatic test_reset_midline();
    int base, n;
    string got, want;
    apply_reset();
    char_out_ready = 1'b1;
    base = cap.len();
    send_move(6, 21, 0);
    n = 0;
    while (cap.len() - base < 2 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) timeouts++;
    rst_in = 1'b0;
    repeat (3) tick();
    rst_in = 1'b1;
    repeat (10) tick();
    got = tail(cap, base);
    n_total++; if (got != "g1") $display("FAIL midline_abandon: got len %0d want \"g1\" (len 2)", got.len()); else n_pass++;
    send_move(1, 18, 0);
    wait_idle();
    got = tail(cap, base);
    want = {"g1", move_line(1, 18, 0)};
    n_total++;
    if (got != want)
      $display("FAIL after_reset_line: got len %0d want len %0d diff@%0d got %h want %h", got.len(), want.len(),
               first_diff(got, want), char_at(got, first_diff(got, want)), char_at(want, first_diff(got, want)));
    else n_pass++;
  endtask

  task automatic test_no_timeouts();
    n_total++; if (timeouts !== 0) $display("FAIL timeouts: got %0d want 0", timeouts); else n_pass++;
  endtask

  initial begin
    rst_in = 1'b0;
    from_in = '0; to_in = '0; promo_in = '0;
    move_in_valid = 1'b0; done_in = 1'b0; char_out_ready = 1'b1;
    b_from = '0; b_to = '0; b_promo = '0;
    b_mvalid = 1'b0; b_done = 1'b0; b_cready = 1'b1;
    test_reset();
    test_latency_e2e4();
    test_promo_count();
    test_fifo_full();
    test_back_to_back();
    test_empty_list();
    test_random_stream();
    test_saturate();
    test_reset_midline();
    test_no_timeouts();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
